// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the BCD range counter.
//   bcd_digit_t : one 4-bit BCD digit
//   DIGIT_MAX   : largest legal value of one BCD digit (9)
//   MAX_DIGITS  : widest counter the conversion helper supports
//   int_to_bcd  : converts a non-negative integer to a packed BCD vector,
//                 digit 0 in bits [3:0]; callers keep the low 4*N bits
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX  = 4'd9;
  localparam int         MAX_DIGITS = 6;

  function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value);
    logic [4*MAX_DIGITS-1:0] result;
    int                      remain;
    result = '0;
    remain = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      result[4*i +: 4] = 4'(remain % 10);
      remain           = remain / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_range_counter_if.sv
// Control/status bundle of the BCD range counter.
//   run, fast_sel, up_dn : counting enable, rate select, direction
//   load, load_val       : one-cycle load request and its BCD value
//   digits               : current count, digit 0 in bits [3:0]
//   step, wrap, load_err : one-cycle status pulses
// master = the side that drives the controls, slave = the counter.
interface bcd_range_counter_if #(
  parameter int NUM_DIGITS = 2
);

  logic                    run;
  logic                    fast_sel;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    step;
  logic                    wrap;
  logic                    load_err;

  modport master (
    output run, fast_sel, up_dn, load, load_val,
    input  digits, step, wrap, load_err
  );

  modport slave (
    input  run, fast_sel, up_dn, load, load_val,
    output digits, step, wrap, load_err
  );

endinterface

// File: rtl/bcd_range_counter_digit.sv
// One decimal digit cell (0..9) of the BCD range counter.
//   clk, reset : clock and asynchronous active-low reset
//   i_inc/i_dec: count this digit up/down by one this cycle
//   i_set      : overwrite the digit with i_setVal (wins over inc/dec)
//   o_digit    : current digit value
//   o_carry    : this digit rolls 9->0 on an increment (feeds next digit)
//   o_borrow   : this digit rolls 0->9 on a decrement (feeds next digit)
module bcd_digit
  import bcd_counter_pkg::*;
#(
  parameter bcd_digit_t RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_set,
  input  bcd_digit_t i_setVal,
  output bcd_digit_t o_digit,
  output logic       o_carry,
  output logic       o_borrow
);

  bcd_digit_t r_digit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit <= RESET_VAL;
    end else if (i_set) begin
      r_digit <= i_setVal;
    end else if (i_inc) begin
      r_digit <= (r_digit == DIGIT_MAX) ? 4'd0 : r_digit + 4'd1;
    end else if (i_dec) begin
      r_digit <= (r_digit == 4'd0) ? DIGIT_MAX : r_digit - 4'd1;
    end
  end

  // Carry/borrow are combinational so a ripple settles within one cycle.
  assign o_carry  = i_inc & (r_digit == DIGIT_MAX);
  assign o_borrow = i_dec & (r_digit == 4'd0);
  assign o_digit  = r_digit;

endmodule

// File: rtl/bcd_range_counter.sv
// BCD up/down counter limited to MIN_VAL..MAX_VAL with a two-rate prescaler.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : control/status bundle (run, fast_sel, up_dn, load,
//                load_val in; digits, step, wrap, load_err out)
// A tick is produced every SLOW_DIV or FAST_DIV cycles while run=1; each
// applied tick moves the count one step and wraps at the range ends.
// A load request always discards a coinciding tick.
module bcd_range_counter
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int MIN_VAL    = 1,
  parameter int MAX_VAL    = 99,
  parameter int SLOW_DIV   = 5_000_000,
  parameter int FAST_DIV   = 1_000_000
) (
  input logic                clk,
  input logic                reset,
  bcd_range_counter_if.slave bus
);

  localparam int W       = 4 * NUM_DIGITS;
  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  // A divide-by-1 in both modes would give a zero-width prescaler.
  localparam int PRE_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [PRE_W-1:0] SLOW_LAST = PRE_W'(SLOW_DIV - 1);
  localparam logic [PRE_W-1:0] FAST_LAST = PRE_W'(FAST_DIV - 1);

  localparam logic [4*MAX_DIGITS-1:0] MIN_FULL = int_to_bcd(MIN_VAL);
  localparam logic [4*MAX_DIGITS-1:0] MAX_FULL = int_to_bcd(MAX_VAL);
  localparam logic [W-1:0]            MIN_BCD  = MIN_FULL[W-1:0];
  localparam logic [W-1:0]            MAX_BCD  = MAX_FULL[W-1:0];

  logic [PRE_W-1:0] r_preCount;
  logic             r_fastPrev;
  logic             r_step;
  logic             r_wrap;
  logic             r_loadErr;

  logic [PRE_W-1:0] w_preLast;
  logic             w_selChange;
  logic             w_tick;
  logic             w_applyTick;
  logic             w_digitsValid;
  logic             w_loadOk;
  logic             w_atMax;
  logic             w_atMin;
  logic             w_overflow;
  logic             w_underflow;
  logic             w_wrapNow;
  logic             w_set;
  logic [W-1:0]     w_setVal;
  logic [W-1:0]     w_count;
  logic             w_incLsd;
  logic             w_decLsd;

  // A rate change is seen one cycle late through r_fastPrev; that cycle
  // clears the prescaler and suppresses the tick.
  assign w_preLast   = bus.fast_sel ? FAST_LAST : SLOW_LAST;
  assign w_selChange = bus.fast_sel != r_fastPrev;
  assign w_tick      = bus.run && !w_selChange && (r_preCount == w_preLast);
  assign w_applyTick = w_tick && !bus.load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preCount <= '0;
      r_fastPrev <= 1'b0;
    end else begin
      r_fastPrev <= bus.fast_sel;
      if (w_selChange) begin
        r_preCount <= '0;
      end else if (bus.run) begin
        r_preCount <= (r_preCount == w_preLast) ? '0 : r_preCount + 1'b1;
      end
    end
  end

  // For well-formed BCD, comparing the packed vectors orders them the same
  // way as their decimal values, so the range test needs no conversion.
  always_comb begin
    w_digitsValid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > DIGIT_MAX) begin
        w_digitsValid = 1'b0;
      end
    end
  end

  assign w_loadOk = w_digitsValid && (bus.load_val >= MIN_BCD) && (bus.load_val <= MAX_BCD);
  assign w_atMax  = (w_count == MAX_BCD);
  assign w_atMin  = (w_count == MIN_BCD);

  // A ripple out of the top digit cannot happen for an in-range count; it
  // is folded into the wrap so a corrupted count still returns to range.
  assign w_wrapNow = w_applyTick &&
                     (bus.up_dn ? (w_atMax || w_overflow) : (w_atMin || w_underflow));
  assign w_set     = (bus.load && w_loadOk) || w_wrapNow;
  assign w_setVal  = bus.load ? bus.load_val : (bus.up_dn ? MIN_BCD : MAX_BCD);
  assign w_incLsd  = w_applyTick && bus.up_dn && !w_atMax;
  assign w_decLsd  = w_applyTick && !bus.up_dn && !w_atMin;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
    logic w_inc;
    logic w_dec;
    logic w_carry;
    logic w_borrow;

    if (g == 0) begin : gFirst
      assign w_inc = w_incLsd;
      assign w_dec = w_decLsd;
    end else begin : gRest
      assign w_inc = gDigit[g-1].w_carry;
      assign w_dec = gDigit[g-1].w_borrow;
    end

    bcd_digit #(
      .RESET_VAL(MIN_BCD[4*g +: 4])
    ) uDigit (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .i_set   (w_set),
      .i_setVal(w_setVal[4*g +: 4]),
      .o_digit (w_count[4*g +: 4]),
      .o_carry (w_carry),
      .o_borrow(w_borrow)
    );
  end

  assign w_overflow  = gDigit[NUM_DIGITS-1].w_carry;
  assign w_underflow = gDigit[NUM_DIGITS-1].w_borrow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_step    <= w_applyTick;
      r_wrap    <= w_wrapNow;
      r_loadErr <= bus.load && !w_loadOk;
    end
  end

  assign bus.digits   = w_count;
  assign bus.step     = r_step;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_loadErr;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Directed bench for bcd_range_counter with NUM_DIGITS=2, range 1..99,
// SLOW_DIV=8 and FAST_DIV=2. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so each waitCycles(n) moves the
// design forward exactly n edges. Expected values are worked out by hand
// from the prescaler position noted beside each step.
module tb_bcd_range_counter;

  localparam int NUM_DIGITS = 2;
  localparam int MIN_VAL    = 1;
  localparam int MAX_VAL    = 99;
  localparam int SLOW_DIV   = 8;
  localparam int FAST_DIV   = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bcd_range_counter_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  bcd_range_counter #(
    .NUM_DIGITS(NUM_DIGITS),
    .MIN_VAL   (MIN_VAL),
    .MAX_VAL   (MAX_VAL),
    .SLOW_DIV  (SLOW_DIV),
    .FAST_DIV  (FAST_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic fast, input logic up,
                               input logic load, input logic [7:0] val);
    bus.run      = run;
    bus.fast_sel = fast;
    bus.up_dn    = up;
    bus.load     = load;
    bus.load_val = val;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] expDigits,
                            input logic expStep, input logic expWrap, input logic expErr);
    checkOutput({tag, ".digits"},   bus.digits,           expDigits);
    checkOutput({tag, ".step"},     {7'd0, bus.step},     {7'd0, expStep});
    checkOutput({tag, ".wrap"},     {7'd0, bus.wrap},     {7'd0, expWrap});
    checkOutput({tag, ".load_err"}, {7'd0, bus.load_err}, {7'd0, expErr});
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    #12;
    checkState("reset", 8'h01, 1'b0, 1'b0, 1'b0);

    // Release with slow rate: ticks land on edges 8 and 16.
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    waitCycles(7);
    checkState("slow_pre7", 8'h01, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("slow_step1", 8'h02, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkState("slow_after1", 8'h02, 1'b0, 1'b0, 1'b0);
    waitCycles(7);
    checkState("slow_step2", 8'h03, 1'b1, 1'b0, 1'b0);

    // Load 98 while switching to fast; the rate change clears the prescaler.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h98);
    waitCycles(1);
    checkState("load98", 8'h98, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    waitCycles(1);
    checkState("fast_pre1", 8'h98, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("up_to99", 8'h99, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkState("wrap_up", 8'h01, 1'b1, 1'b1, 1'b0);
    bus.up_dn = 1'b0;
    waitCycles(1);
    checkState("wrap_clear", 8'h01, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("wrap_down", 8'h99, 1'b1, 1'b1, 1'b0);

    // Carry and borrow; each load lands at prescaler 0, tick follows next edge.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h09);
    waitCycles(1);
    checkState("load09", 8'h09, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    waitCycles(1);
    checkState("carry09", 8'h10, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h19);
    waitCycles(1);
    bus.load = 1'b0;
    waitCycles(1);
    checkState("carry19", 8'h20, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
    waitCycles(1);
    checkState("load10", 8'h10, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    waitCycles(1);
    checkState("borrow10", 8'h09, 1'b1, 1'b0, 1'b0);

    // Rejected loads with run=0, then a good one.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    waitCycles(1);
    checkState("bad_5A", 8'h09, 1'b0, 1'b0, 1'b1);
    bus.load_val = 8'h00;
    waitCycles(1);
    checkState("bad_00", 8'h09, 1'b0, 1'b0, 1'b1);
    bus.load_val = 8'h42;
    waitCycles(1);
    checkState("good_42", 8'h42, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    waitCycles(1);
    checkState("idle_42", 8'h42, 1'b0, 1'b0, 1'b0);

    // Load on the tick edge: load wins, prescaler still restarts at 0.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(1);
    checkState("pre1_42", 8'h42, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    waitCycles(1);
    checkState("load_tick", 8'h55, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    waitCycles(1);
    checkState("after_lt", 8'h55, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("step56", 8'h56, 1'b1, 1'b0, 1'b0);

    // Rate toggles mid-period: each change clears the prescaler, no step.
    bus.fast_sel = 1'b0;
    waitCycles(1);
    checkState("to_slow", 8'h56, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkState("slow_pre3", 8'h56, 1'b0, 1'b0, 1'b0);
    bus.fast_sel = 1'b1;
    waitCycles(1);
    checkState("to_fast", 8'h56, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("fast_pre1b", 8'h56, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("step57", 8'h57, 1'b1, 1'b0, 1'b0);

    // Hold with prescaler at 1; resuming ticks on the very next edge.
    waitCycles(1);
    bus.run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      checkState("hold", 8'h57, 1'b0, 1'b0, 1'b0);
    end
    bus.run = 1'b1;
    waitCycles(1);
    checkState("resume", 8'h58, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count with a load pending.
    waitCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
    reset = 1'b0;
    #1;
    checkState("async_rst", 8'h01, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("rst_held", 8'h01, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    waitCycles(7);
    checkState("rst_pre7", 8'h01, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkState("rst_step", 8'h02, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
